cache_ctrl: RTL
===============

// Module: cache_ctrl
// PURPOSE
//  Cache management FSM that initiates every operation on the 2-way set-associative cache storage block.
//  - Serves CPU loads/stores.
//  - Hit: completes in 2 cycles. Miss: writes back a dirty LRU victim line, refills 4 words from memory,
//    then replays the access.
//  - Sits between CPU MEM stage, cache array and word-wide main memory port.
// PARAMETERS
//  ADDR_BITS   32  address width; tag[31:9], index[8:4], word[3:2], byte[1:0]
//  LINE_WORDS  4   words per line; word counter width = 2
//  TAG_BITS    23  victim tag width
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  en_r           in   1   CPU read request; held stable while stall=1
//  en_w           in   1   CPU write request; held stable while stall=1 (en_r&en_w illegal)
//  addr           in   32  CPU byte address
//  u_b_h_w        in   3   CPU width/sign code (LB/LH/LW/LBU/LHU/SB/SH/SW encoding)
//  data_w         in   32  CPU store data
//  data_r         out  32  CPU load data, registered
//  stall          out  1   combinational; CPU must hold its request while high
//  cache_addr     out  32  address to cache
//  cache_load     out  1   cache read with LRU refresh
//  cache_edit     out  1   cache write from CPU
//  cache_store    out  1   cache line fill, one word per pulse
//  cache_invalid  out  1   tied 0, reserved for flush
//  cache_u_b_h_w  out  3   CPU code during access, 3'b010 (word) otherwise
//  cache_din      out  32  data_w on edit, mem_din on store
//  cache_hit      in   1   registered, 1 cycle after load/edit
//  cache_dout     in   32  registered; with load=0, holds LRU-victim word at cache_addr
//  cache_valid    in   1   registered victim valid
//  cache_dirty    in   1   registered victim dirty
//  cache_tag      in   23  registered victim tag
//  mem_cs         out  1   memory request
//  mem_we         out  1   1=write, 0=read
//  mem_addr       out  32  word-aligned memory address
//  mem_dout       out  32  writeback data (= cache_dout)
//  mem_din        in   32  refill data, valid with mem_ack
//  mem_ack        in   1   1-cycle completion pulse for current cs request
// BEHAVIOUR
//  States: IDLE, CHECK, WB_RD, WB_WR, FILL. Reset -> IDLE, word cnt=0, data_r=0, victim tag reg=0.
//    All cache_* and mem_* strobes are 0 in reset/IDLE without request.
//  IDLE
//    - Request present: cache_addr=addr, cache_load=en_r, cache_edit=en_w, cache_din=data_w -> CHECK.
//    - Edit writes the same cycle only if the line is present.
//  CHECK
//    - cache_hit=1: data_r<=cache_dout (read), stall=0 this cycle -> IDLE.
//    - Miss with cache_valid&cache_dirty: latch cache_tag, cnt=0 -> WB_RD.
//    - Any other miss -> FILL, cnt=0.
//  WB_RD (1 cycle): cache_addr={addr[31:4],cnt,2'b00}, load=0 -> WB_WR.
//  WB_WR
//    - Same cache_addr; mem_cs=1, mem_we=1, mem_addr={victim_tag,addr[8:4],cnt,2'b00}, mem_dout=cache_dout.
//    - On ack: cnt==3 -> FILL with cnt=0, else cnt+1 -> WB_RD.
//  FILL
//    - mem_cs=1, mem_we=0, mem_addr={addr[31:4],cnt,2'b00}.
//    - On ack: cache_store=1, cache_addr=mem_addr, cache_din=mem_din same cycle; cnt==3 -> IDLE (cnt wraps to 0), else cnt+1.
//  Replay: request still held after FILL; IDLE reissues it and CHECK then hits. Write miss = write-allocate.
//  stall = (en_r|en_w) & ~(state==CHECK & cache_hit). Hit costs 1 stall cycle.
//  mem_cs, mem_addr, mem_we are held constant until mem_ack; no request without cs; ack outside WB_WR/FILL ignored.
//  rst in any state, including mid-burst: next cycle IDLE, cs=0, cnt=0. Partial refill is left as-is.
//  Exactly one of load/edit/store is high per cycle.
// TESTING
//  - Cold read miss: en_r, addr=0x0000_0210, mem returns 0x11,0x22,0x33,0x44
//    -> 4 reads at 0x210/214/218/21C, 4 store pulses, then data_r=0x11 with stall low.
//  - Read hit on 0x214 after the above -> stall high 1 cycle, data_r=0x22, no mem_cs.
//  - Write hit: SW 0xDEADBEEF to 0x218 -> one edit pulse, no mem traffic; later LW 0x218 returns 0xDEADBEEF.
//  - Dirty eviction: fill both ways of index 1, dirty LRU tag 0x5, read tag 0x7
//    -> writes to 0xA10..0xA1C precede reads from 0xE10..0xE1C.
//  - mem_ack delayed 3 cycles per word -> mem_cs, mem_addr, mem_we stable until ack; cnt advances only on ack.
//  - rst after 2nd refill ack -> next cycle IDLE, mem_cs=0, stall follows en_r, data_r=0.

Source files
------------

// File: rtl/cache_ctrl.sv
// Cache management FSM for a 2-way set-associative cache: serves CPU loads/stores,
// writes back dirty victims and refills lines over a word-wide memory port.
module cache_ctrl #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_BITS   = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_store,
  output logic                 cache_invalid,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic [31:0]          cache_dout,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_dout,
  input  logic [31:0]          mem_din,
  input  logic                 mem_ack
);

  localparam int unsigned CntBits = $clog2(LINE_WORDS);
  localparam logic [CntBits-1:0] LastWord = CntBits'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWbRd,
    StWbWr,
    StFill
  } state_e;

  state_e               state_q, state_d;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic [31:0]          data_r_q, data_r_d;
  logic [TAG_BITS-1:0]  victim_tag_q, victim_tag_d;
  logic                 req;
  logic [ADDR_BITS-1:0] line_addr;

  assign req       = en_r | en_w;
  assign line_addr = {addr[ADDR_BITS-1:4], cnt_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      data_r_q     <= '0;
      victim_tag_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_r_q     <= data_r_d;
      victim_tag_q <= victim_tag_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_r_d      = data_r_q;
    victim_tag_d  = victim_tag_q;
    cache_addr    = addr;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_store   = 1'b0;
    cache_u_b_h_w = 3'b010;
    cache_din     = data_w;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = line_addr;

    unique case (state_q)
      StIdle: begin
        // Strobes stay quiet while reset is held even if the CPU keeps its request up.
        if (req && !rst) begin
          cache_load    = en_r;
          cache_edit    = en_w;
          cache_u_b_h_w = u_b_h_w;
          state_d       = StCheck;
        end
      end
      StCheck: begin
        cache_u_b_h_w = u_b_h_w;
        cnt_d         = '0;
        if (cache_hit) begin
          if (en_r) data_r_d = cache_dout;
          state_d = StIdle;
        end else if (cache_valid && cache_dirty) begin
          victim_tag_d = cache_tag;
          state_d      = StWbRd;
        end else begin
          state_d = StFill;
        end
      end
      StWbRd: begin
        cache_addr = line_addr;
        state_d    = StWbWr;
      end
      StWbWr: begin
        cache_addr = line_addr;
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {victim_tag_q, addr[8:4], cnt_q, 2'b00};
        if (mem_ack) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LastWord) ? StFill : StWbRd;
        end
      end
      StFill: begin
        mem_cs = 1'b1;
        if (mem_ack) begin
          cache_store = 1'b1;
          cache_addr  = line_addr;
          cache_din   = mem_din;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LastWord) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign stall         = req & ~((state_q == StCheck) & cache_hit);
  assign data_r        = data_r_q;
  assign mem_dout      = cache_dout;
  assign cache_invalid = 1'b0;

endmodule
